pc_unit: RTL and testbench



---
 rtl/pc_pkg.sv | 19 +
 rtl/pc_ras.sv | 67 ++++++
 rtl/pc_unit.sv | 127 ++++++++++++
 tb/tb_pc_unit.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch program-counter unit.
// Latency: n/a (types only).
// Backpressure: n/a.
package pc_pkg;

    // Fetch-unit control state.
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    // Default geometry; modules re-derive these from their own parameters.
    localparam int PC_DEF_INC       = 4;
    localparam int PC_DEF_RAS_DEPTH = 4;
    localparam int RAS_PTR_W        = $clog2(PC_DEF_RAS_DEPTH);
    localparam int ALIGN_BITS       = $clog2(PC_DEF_INC);

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; the oldest entry is overwritten when full.
// Latency: push/pop take effect on the next edge; top is read combinationally.
// Backpressure: none -- pushes never stall, count saturates at RAS_DEPTH.
module pc_ras #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic                           pop,
    input  logic [ADDR_W-1:0]              push_data,
    output logic [ADDR_W-1:0]              top,
    output logic                           empty,
    output logic [$clog2(RAS_DEPTH+1)-1:0] count
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  ptr_inc;
    logic [PTR_W-1:0]  ptr_dec;

    assign ptr_inc = ptr + PTR_W'(1);
    assign ptr_dec = ptr - PTR_W'(1);
    assign top     = mem[ptr];
    assign empty   = (count == '0);

    // Storage: push+pop rewrites the current top in place; plain push writes the next slot.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (push && pop) begin
                mem[ptr] <= push_data;
            end else if (push) begin
                mem[ptr_inc] <= push_data;
            end
        end
    end

    // Top pointer wraps naturally, which gives the circular overwrite on overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (push && !pop) begin
            ptr <= ptr_inc;
        end else if (pop && !push) begin
            ptr <= ptr_dec;
        end
    end

    // Occupancy saturates at depth on push and floors at zero on pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (push && !pop) begin
            if (count != CNT_W'(RAS_DEPTH)) begin
                count <= count + CNT_W'(1);
            end
        end else if (pop && !push) begin
            if (count != '0) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter: sequential advance, stall, redirect, exception, halt, RAS call/return.
// Latency: every update lands on the next rising edge; pc_addr/pc_valid/ras_miss are registered.
// Backpressure: stall holds pc and RAS; RAS pushes never stall.
module pc_unit
    import pc_pkg::*;
#(
    parameter int              ADDR_W    = 32,
    parameter int              INC       = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int              RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              halt,
    input  logic              exc,
    input  logic [ADDR_W-1:0] exc_vec,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              call,
    input  logic [ADDR_W-1:0] call_target,
    input  logic              ret,
    output logic [ADDR_W-1:0] pc_addr,
    output logic              pc_valid,
    output logic              ras_empty,
    output logic              ras_miss
);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    // Clears the low log2(INC) bits of any loaded target.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(INC) - ADDR_W'(1));

    pc_state_t         state_q;
    pc_state_t         state_d;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_seq;
    logic              miss_d;
    logic              ras_push;
    logic              ras_pop;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_is_empty;
    logic [CNT_W-1:0]  ras_count;

    assign pc_seq    = pc_addr + ADDR_W'(INC);
    assign ras_empty = ras_is_empty;

    pc_ras #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_seq),
        .top       (ras_top),
        .empty     (ras_is_empty),
        .count     (ras_count)
    );

    // Next-state and next-pc selection; exc > redirect > halt > stall > ret/call > advance.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_addr;
        miss_d   = 1'b0;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (exc) begin
                    pc_d = exc_vec & ALIGN_MASK;
                end else if (redirect) begin
                    pc_d = redirect_addr & ALIGN_MASK;
                end else if (halt) begin
                    state_d = HALT;
                end else if (stall) begin
                    pc_d = pc_addr;
                end else if (call) begin
                    // With ret also set, a non-empty stack swaps its top in place.
                    ras_push = 1'b1;
                    ras_pop  = ret && (ras_count != '0);
                    pc_d     = call_target & ALIGN_MASK;
                end else if (ret) begin
                    if (ras_count == '0) begin
                        pc_d   = pc_seq;
                        miss_d = 1'b1;
                    end else begin
                        ras_pop = 1'b1;
                        pc_d    = ras_top & ALIGN_MASK;
                    end
                end else begin
                    pc_d = pc_seq;
                end
            end
            HALT: begin
                if (exc) begin
                    state_d = RUN;
                    pc_d    = exc_vec & ALIGN_MASK;
                end else if (redirect) begin
                    state_d = RUN;
                    pc_d    = redirect_addr & ALIGN_MASK;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State, pc and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= BOOT;
            pc_addr  <= RESET_VEC;
            pc_valid <= 1'b0;
            ras_miss <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_addr  <= pc_d;
            pc_valid <= (state_d == RUN);
            ras_miss <= miss_d;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic        vld;
        logic        emp;
        logic        miss;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset, stall, halt, exc, redirect, call, ret;
    logic [31:0] exc_vec, redirect_addr, call_target;
    logic [31:0] pc_addr;
    logic        pc_valid, ras_empty, ras_miss;

    logic        zero1 = 1'b0;
    logic [7:0]  zero8 = 8'h00;
    logic [7:0]  pc2;
    logic        pc2_valid, pc2_empty, pc2_miss;

    int   vectors = 0;
    int   errors  = 0;
    obs_t exp_q[$];
    obs_t obs_q[$];

    always #5 clk = ~clk;

    pc_unit #(.ADDR_W(32), .INC(4), .RESET_VEC(32'h100), .RAS_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .stall(stall), .halt(halt), .exc(exc), .exc_vec(exc_vec),
        .redirect(redirect), .redirect_addr(redirect_addr), .call(call), .call_target(call_target),
        .ret(ret), .pc_addr(pc_addr), .pc_valid(pc_valid), .ras_empty(ras_empty), .ras_miss(ras_miss)
    );

    pc_unit #(.ADDR_W(8), .INC(4), .RESET_VEC(8'hFC), .RAS_DEPTH(4)) dut8 (
        .clk(clk), .reset(reset), .stall(zero1), .halt(zero1), .exc(zero1), .exc_vec(zero8),
        .redirect(zero1), .redirect_addr(zero8), .call(zero1), .call_target(zero8),
        .ret(zero1), .pc_addr(pc2), .pc_valid(pc2_valid), .ras_empty(pc2_empty), .ras_miss(pc2_miss)
    );

    // Drive one cycle of inputs, queue the expected post-edge state, capture the observed one.
    task automatic step(input logic rs, input logic st, input logic hl,
                        input logic ex, input logic [31:0] ev,
                        input logic rd, input logic [31:0] ra,
                        input logic cl, input logic [31:0] ct, input logic rt,
                        input logic [31:0] e_pc, input logic e_vld, input logic e_emp, input logic e_miss);
        obs_t e;
        obs_t o;
        reset = rs; stall = st; halt = hl; exc = ex; exc_vec = ev;
        redirect = rd; redirect_addr = ra; call = cl; call_target = ct; ret = rt;
        e.pc = e_pc; e.vld = e_vld; e.emp = e_emp; e.miss = e_miss;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        o.pc = pc_addr; o.vld = pc_valid; o.emp = ras_empty; o.miss = ras_miss;
        obs_q.push_back(o);
    endtask

    // Plain sequential cycle.
    task automatic idle(input logic [31:0] e_pc, input logic e_vld, input logic e_emp, input logic e_miss);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e_pc, e_vld, e_emp, e_miss);
    endtask

    task automatic test_reset;
        logic [7:0] exp8 [4];
        exp8[0] = 8'hFC; exp8[1] = 8'hFC; exp8[2] = 8'h00; exp8[3] = 8'h04;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100, 0, 1, 0);
        if (pc2 !== exp8[0]) begin errors++; $display("FAIL wrap8[0] pc got %h want %h", pc2, exp8[0]); end
        vectors++;
        for (int i = 1; i < 4; i++) begin
            idle(32'h100 + 32'(4 * (i - 1)), 1'(i == 1) | 1'(i > 1), 1, 0);
            vectors++;
            if (pc2 !== exp8[i]) begin errors++; $display("FAIL wrap8[%0d] pc got %h want %h", i, pc2, exp8[i]); end
        end
        // First RUN cycle above shows the BOOT bubble ended; confirm BOOT itself was invalid.
        while (exp_q.size() > 0) begin
            obs_t e = exp_q.pop_front();
            obs_t o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin errors++; $display("FAIL reset got %h want %h", o, e); end
        end
    endtask

    task automatic test_stall;
        step(0, 0, 0, 0, 0, 1, 32'h20, 0, 0, 0, 32'h20, 1, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h20, 1, 1, 0);
        idle(32'h24, 1, 1, 0);
        step(0, 1, 0, 0, 0, 1, 32'h80, 0, 0, 0, 32'h80, 1, 1, 0);
        // Call/ret ignored while stalled.
        step(0, 1, 0, 0, 0, 0, 0, 1, 32'h300, 1, 32'h80, 1, 1, 0);
        while (exp_q.size() > 0) begin
            obs_t e = exp_q.pop_front();
            obs_t o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin errors++; $display("FAIL stall got %h want %h", o, e); end
        end
    endtask

    task automatic test_call_ret;
        step(0, 0, 0, 0, 0, 1, 32'h40, 0, 0, 0, 32'h40, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h200, 0, 32'h200, 1, 0, 0);
        idle(32'h204, 1, 0, 0);
        idle(32'h208, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h44, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h48, 1, 1, 1);
        idle(32'h4C, 1, 1, 0);
        while (exp_q.size() > 0) begin
            obs_t e = exp_q.pop_front();
            obs_t o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin errors++; $display("FAIL call_ret got %h want %h", o, e); end
        end
    endtask

    task automatic test_ras_overflow;
        step(0, 0, 0, 0, 0, 1, 32'h10, 0, 0, 0, 32'h10, 1, 1, 0);
        for (int i = 1; i <= 5; i++)
            step(0, 0, 0, 0, 0, 0, 0, 1, 32'h10 + 32'(i * 'h100), 0, 32'h10 + 32'(i * 'h100), 1, 0, 0);
        for (int i = 4; i >= 1; i--)
            step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h14 + 32'(i * 'h100), 1, 1'(i == 1), 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h118, 1, 1, 1);
        while (exp_q.size() > 0) begin
            obs_t e = exp_q.pop_front();
            obs_t o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin errors++; $display("FAIL ras_overflow got %h want %h", o, e); end
        end
    endtask

    task automatic test_halt;
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h300, 0, 32'h300, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h300, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h500, 1, 32'h300, 0, 0, 0);
        idle(32'h300, 0, 0, 0);
        step(0, 0, 0, 1, 32'h8, 1, 32'h90, 0, 0, 0, 32'h8, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h11C, 1, 1, 0);
        step(0, 0, 0, 0, 0, 1, 32'h93, 0, 0, 0, 32'h90, 1, 1, 0);
        step(0, 1, 1, 1, 32'h1003, 1, 32'h55, 0, 0, 0, 32'h1000, 1, 1, 0);
        while (exp_q.size() > 0) begin
            obs_t e = exp_q.pop_front();
            obs_t o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin errors++; $display("FAIL halt got %h want %h", o, e); end
        end
    endtask

    task automatic test_back_to_back;
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h500, 0, 32'h500, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h602, 1, 32'h600, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h504, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h700, 1, 32'h700, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h800, 0, 32'h800, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 32'h900, 0, 32'h100, 0, 1, 0);
        idle(32'h100, 1, 1, 0);
        idle(32'h104, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h108, 1, 1, 1);
        while (exp_q.size() > 0) begin
            obs_t e = exp_q.pop_front();
            obs_t o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin errors++; $display("FAIL back_to_back got %h want %h", o, e); end
        end
    endtask

    initial begin
        reset = 1; stall = 0; halt = 0; exc = 0; redirect = 0; call = 0; ret = 0;
        exc_vec = 0; redirect_addr = 0; call_target = 0;
        #2;
        test_reset;
        test_stall;
        test_call_ret;
        test_ras_overflow;
        test_halt;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
